// File: rtl/serv_bufreg_pkg.sv
// Shared types and constants for the parametrised serial buffer register.
package serv_bufreg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int CNT_W = 6;

    localparam logic MODE_LOAD  = 1'b0;
    localparam logic MODE_SHIFT = 1'b1;

    function automatic int beats_of(input int w);
        return 32 / w;
    endfunction

endpackage

// File: rtl/serv_bufreg_sadd.sv
// W-bit slice of a serial adder; the carry register links consecutive beats.
module serv_bufreg_sadd #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q
);
    import serv_bufreg_pkg::*;

    logic         carry_q;
    logic         carry_d;
    logic [W:0]   sum;

    assign sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_q};
    assign q   = sum[W-1:0];

    // Clear wins over accumulate so a new operation never inherits a stale carry.
    always_comb begin
        carry_d = carry_q;
        if (clr) begin
            carry_d = 1'b0;
        end else if (en) begin
            carry_d = sum[W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/serv_bufreg_w.sv
// Self-sequencing serial buffer register: W-bit serial add (LOAD) or right shift (SHIFT).
// Optional macro SERV_BUFREG_MDU_EN masks o_lsb to zero during MDU operations.
module serv_bufreg_w #(
    parameter int W = 1,
    parameter int B = W - 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_mode,
    input  logic [5:0]    i_nbeats,
    input  logic          i_rs1_en,
    input  logic          i_imm_en,
    input  logic          i_clr_lsb,
    input  logic          i_sh_signed,
    input  logic          i_mdu_op,
    input  logic [B:0]    i_rs1,
    input  logic [B:0]    i_imm,
    output logic          o_busy,
    output logic          o_done,
    output logic [B:0]    o_q,
    output logic [1:0]    o_lsb,
    output logic [31:0]   o_dbus_adr,
    output logic [31:0]   o_ext_rs1
);
    import serv_bufreg_pkg::*;

    localparam int               BEATS     = beats_of(W);
    localparam logic [CNT_W-1:0] BEATS_C   = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(BEATS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             mode_q, mode_d;
    logic [31:0]      data_q, data_d;

    logic             start_ok;
    logic             load_beat;
    logic             shift_beat;
    logic             last_beat;
    logic [B:0]       clrmask;
    logic [B:0]       add_a;
    logic [B:0]       add_b;
    logic [B:0]       add_q;

    assign start_ok   = (state_q == IDLE) && i_start;
    assign load_beat  = (state_q == ACTIVE) && (mode_q == MODE_LOAD);
    assign shift_beat = (state_q == ACTIVE) && (mode_q == MODE_SHIFT) && (len_q != '0);
    // A zero-length shift still spends one ACTIVE cycle so DONE timing stays uniform.
    assign last_beat  = (mode_q == MODE_LOAD) ? (cnt_q == LAST_LOAD)
                                              : ((len_q == '0) || (cnt_q == len_q - 1'b1));

    assign clrmask = W'(i_clr_lsb && (cnt_q == '0));
    assign add_a   = i_rs1 & {W{i_rs1_en}};
    assign add_b   = i_imm & {W{i_imm_en}} & ~clrmask;

    serv_bufreg_sadd #(.W(W)) u_sadd (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (start_ok),
        .en    (load_beat),
        .a     (add_a),
        .b     (add_b),
        .q     (add_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    mode_d  = i_mode;
                    len_d   = (i_nbeats > BEATS_C) ? BEATS_C : i_nbeats;
                    cnt_d   = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (load_beat) begin
                    data_d = {add_q, data_q[31:W]};
                end else if (shift_beat) begin
                    data_d = {{W{data_q[31] & i_sh_signed}}, data_q[31:W]};
                end
                cnt_d = cnt_q + 1'b1;
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= MODE_LOAD;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
        end
    end

    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);
    assign o_q        = shift_beat ? data_q[B:0] : '0;
    assign o_dbus_adr = {data_q[31:2], 2'b00};
    assign o_ext_rs1  = data_q;

`ifdef SERV_BUFREG_MDU_EN
    assign o_lsb = i_mdu_op ? 2'b00 : data_q[1:0];
`else
    logic unused_mdu_op;
    assign unused_mdu_op = i_mdu_op;
    assign o_lsb         = data_q[1:0];
`endif

endmodule

// File: tb/tb_serv_bufreg_w.sv
// Directed scoreboard bench for serv_bufreg_w, driving W=1, W=4 and W=8 instances side by side.
module tb_serv_bufreg_w;

    logic        clk = 1'b0;
    logic        rstN;
    logic [2:0]  startV;
    logic        mode;
    logic [5:0]  nbeats;
    logic        rs1En, immEn, clrLsb, shSigned, mduOp;
    logic [7:0]  rs1Bus, immBus;

    logic [2:0]  busyV, doneV;
    logic [0:0]  q1;
    logic [3:0]  q4;
    logic [7:0]  q8;
    logic [1:0]  lsb1, lsb4, lsb8;
    logic [31:0] adr1, adr4, adr8, ext1, ext4, ext8;

    int          sel;
    logic        obsBusy, obsDone;
    logic [7:0]  obsQ;
    logic [1:0]  obsLsb;
    logic [31:0] obsAdr, obsExt;

    logic [31:0] sbQ[$];
    int          checks = 0;
    int          errors = 0;
    int          doneSeen;

    always #5 clk = ~clk;

    serv_bufreg_w #(.W(1)) u1 (
        .i_clk(clk), .i_rst_n(rstN), .i_start(startV[0]), .i_mode(mode), .i_nbeats(nbeats),
        .i_rs1_en(rs1En), .i_imm_en(immEn), .i_clr_lsb(clrLsb), .i_sh_signed(shSigned),
        .i_mdu_op(mduOp), .i_rs1(rs1Bus[0:0]), .i_imm(immBus[0:0]),
        .o_busy(busyV[0]), .o_done(doneV[0]), .o_q(q1), .o_lsb(lsb1),
        .o_dbus_adr(adr1), .o_ext_rs1(ext1)
    );

    serv_bufreg_w #(.W(4)) u4 (
        .i_clk(clk), .i_rst_n(rstN), .i_start(startV[1]), .i_mode(mode), .i_nbeats(nbeats),
        .i_rs1_en(rs1En), .i_imm_en(immEn), .i_clr_lsb(clrLsb), .i_sh_signed(shSigned),
        .i_mdu_op(mduOp), .i_rs1(rs1Bus[3:0]), .i_imm(immBus[3:0]),
        .o_busy(busyV[1]), .o_done(doneV[1]), .o_q(q4), .o_lsb(lsb4),
        .o_dbus_adr(adr4), .o_ext_rs1(ext4)
    );

    serv_bufreg_w #(.W(8)) u8 (
        .i_clk(clk), .i_rst_n(rstN), .i_start(startV[2]), .i_mode(mode), .i_nbeats(nbeats),
        .i_rs1_en(rs1En), .i_imm_en(immEn), .i_clr_lsb(clrLsb), .i_sh_signed(shSigned),
        .i_mdu_op(mduOp), .i_rs1(rs1Bus[7:0]), .i_imm(immBus[7:0]),
        .o_busy(busyV[2]), .o_done(doneV[2]), .o_q(q8), .o_lsb(lsb8),
        .o_dbus_adr(adr8), .o_ext_rs1(ext8)
    );

    always_comb begin
        obsBusy = 1'b0;
        obsDone = 1'b0;
        obsQ    = 8'h00;
        obsLsb  = 2'b00;
        obsAdr  = 32'h0;
        obsExt  = 32'h0;
        case (sel)
            0: begin
                obsBusy = busyV[0]; obsDone = doneV[0]; obsQ = {7'h0, q1};
                obsLsb = lsb1; obsAdr = adr1; obsExt = ext1;
            end
            1: begin
                obsBusy = busyV[1]; obsDone = doneV[1]; obsQ = {4'h0, q4};
                obsLsb = lsb4; obsAdr = adr4; obsExt = ext4;
            end
            default: begin
                obsBusy = busyV[2]; obsDone = doneV[2]; obsQ = q8;
                obsLsb = lsb8; obsAdr = adr8; obsExt = ext8;
            end
        endcase
    end

    function automatic int widthOf(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 4 : 8);
    endfunction

    function automatic logic [7:0] sliceOf(input logic [31:0] v, input int k, input int w);
        logic [31:0] t;
        t = v >> (k * w);
        return 8'(t & ((32'd1 << w) - 32'd1));
    endfunction

    function automatic logic [31:0] popExpected();
        if (sbQ.size() == 0) return 32'hDEAD_BEEF;
        return sbQ.pop_front();
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one operation on instance idx from a negedge; poke re-asserts start mid-run and in DONE.
    task automatic applyStimulus(input string tag, input int idx, input logic isShift,
                                 input logic [5:0] nb, input logic [31:0] rs1, input logic [31:0] imm,
                                 input logic clr, input logic sgn, input logic poke,
                                 input logic [31:0] startData, input logic [31:0] expFinal,
                                 input int expLatency);
        int          w;
        int          beats;
        int          effLen;
        int          lat;
        int          k;
        bit          seen;
        logic [31:0] d;
        logic [31:0] fill;
        w      = widthOf(idx);
        beats  = 32 / w;
        effLen = (int'(nb) > beats) ? beats : int'(nb);
        sbQ.delete();
        if (isShift) begin
            d    = startData;
            fill = ~(32'hFFFF_FFFF >> w);
            for (int i = 0; i < effLen; i++) begin
                sbQ.push_back(d & ((32'd1 << w) - 32'd1));
                d = (d >> w) | ((sgn && d[31]) ? fill : 32'h0);
            end
        end
        sbQ.push_back(expFinal);

        sel      = idx;
        mode     = isShift;
        nbeats   = nb;
        clrLsb   = clr;
        shSigned = sgn;
        rs1En    = 1'b1;
        immEn    = 1'b1;
        startV   = 3'b001 << idx;
        rs1Bus   = sliceOf(rs1, 0, w);
        immBus   = sliceOf(imm, 0, w);
        lat      = 1;
        seen     = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            k = lat - 2;
            if (obsDone === 1'b1) begin
                seen   = 1'b1;
                startV = poke ? (3'b001 << idx) : 3'b000;
            end else begin
                startV = (poke && k == 2) ? (3'b001 << idx) : 3'b000;
                if (isShift && k < effLen)
                    checkOutput($sformatf("%s q beat %0d", tag, k), {24'h0, obsQ}, popExpected());
                else if (!isShift && k == 1)
                    checkOutput({tag, " q during load"}, {24'h0, obsQ}, 32'h0);
                rs1Bus = sliceOf(rs1, k, w);
                immBus = sliceOf(imm, k, w);
            end
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLatency));
        checkOutput({tag, " data"}, obsExt, popExpected());
        @(negedge clk);
        startV = 3'b000;
        checkOutput({tag, " idle after done"}, {30'h0, obsBusy, obsDone}, 32'h0);
    endtask

    initial begin
        rstN = 1'b0; startV = 3'b000; mode = 1'b0; nbeats = 6'd0;
        rs1En = 1'b0; immEn = 1'b0; clrLsb = 1'b0; shSigned = 1'b0; mduOp = 1'b0;
        rs1Bus = 8'h00; immBus = 8'h00; sel = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            checkOutput($sformatf("reset busy/done w%0d", widthOf(i)), {30'h0, obsBusy, obsDone}, 32'h0);
            checkOutput($sformatf("reset q/lsb w%0d", widthOf(i)), {22'h0, obsQ, obsLsb}, 32'h0);
            checkOutput($sformatf("reset ext w%0d", widthOf(i)), obsExt, 32'h0);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        applyStimulus("w1 load", 0, 1'b0, 6'd0, 32'h0000_1000, 32'h0000_0FFC, 1'b0, 1'b0, 1'b0,
                      32'h0, 32'h0000_1FFC, 34);
        checkOutput("w1 load adr", obsAdr, 32'h0000_1FFC);
        checkOutput("w1 load lsb", {30'h0, obsLsb}, 32'h0);

        applyStimulus("w1 clr_lsb", 0, 1'b0, 6'd0, 32'h0000_0100, 32'h0000_0003, 1'b1, 1'b0, 1'b0,
                      32'h0, 32'h0000_0102, 34);
        checkOutput("w1 clr_lsb lsb", {30'h0, obsLsb}, 32'h2);
        checkOutput("w1 clr_lsb adr", obsAdr, 32'h0000_0100);

        applyStimulus("w4 wrap", 1, 1'b0, 6'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0,
                      32'h0, 32'h0000_0000, 10);
        applyStimulus("w4 carry cleared", 1, 1'b0, 6'd0, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0, 1'b0,
                      32'h0, 32'h0000_000B, 10);

        applyStimulus("w4 preload s", 1, 1'b0, 6'd0, 32'h8000_0001, 32'h0, 1'b0, 1'b0, 1'b0,
                      32'h0, 32'h8000_0001, 10);
        applyStimulus("w4 shift signed", 1, 1'b1, 6'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0,
                      32'h8000_0001, 32'hFF80_0000, 4);
        applyStimulus("w4 preload u", 1, 1'b0, 6'd0, 32'h8000_0001, 32'h0, 1'b0, 1'b0, 1'b0,
                      32'h0, 32'h8000_0001, 10);
        applyStimulus("w4 shift unsigned", 1, 1'b1, 6'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0,
                      32'h8000_0001, 32'h0080_0000, 4);
        applyStimulus("w4 shift zero len", 1, 1'b1, 6'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0,
                      32'h0080_0000, 32'h0080_0000, 3);

        applyStimulus("w8 load plain", 2, 1'b0, 6'd0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0,
                      32'h0, 32'h2345_6789, 6);
        applyStimulus("w8 load poked", 2, 1'b0, 6'd0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1,
                      32'h0, 32'h2345_6789, 6);
        applyStimulus("w8 preload", 2, 1'b0, 6'd0, 32'h8765_4321, 32'h0, 1'b0, 1'b0, 1'b0,
                      32'h0, 32'h8765_4321, 6);
        applyStimulus("w8 shift clamp", 2, 1'b1, 6'd40, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0,
                      32'h8765_4321, 32'hFFFF_FFFF, 6);

        // Abort a W=8 load at beat 2 with reset; no DONE may follow.
        sel = 2; mode = 1'b0; rs1En = 1'b1; immEn = 1'b1; clrLsb = 1'b0;
        startV = 3'b100; rs1Bus = 8'h11; immBus = 8'h22;
        @(negedge clk);
        startV = 3'b000;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("abort busy/done", {30'h0, obsBusy, obsDone}, 32'h0);
        checkOutput("abort q/lsb", {22'h0, obsQ, obsLsb}, 32'h0);
        checkOutput("abort adr", obsAdr, 32'h0);
        checkOutput("abort ext", obsExt, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (obsDone === 1'b1 || obsBusy === 1'b1) doneSeen++;
        end
        checkOutput("abort no done", 32'(doneSeen), 32'h0);

        applyStimulus("w1 mdu preload", 0, 1'b0, 6'd0, 32'h0000_0003, 32'h0, 1'b0, 1'b0, 1'b0,
                      32'h0, 32'h0000_0003, 34);
        mduOp = 1'b1;
        #1;
`ifdef SERV_BUFREG_MDU_EN
        checkOutput("mdu lsb masked", {30'h0, obsLsb}, 32'h0);
`else
        checkOutput("mdu lsb ignored", {30'h0, obsLsb}, 32'h3);
`endif
        mduOp = 1'b0;
        #1;
        checkOutput("non-mdu lsb", {30'h0, obsLsb}, 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
